// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the page-table walker, CPU data side and
// instruction fetch. Fixed priority ptw > d > i, with a starvation guard for fetch.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ptw_req,
    input  logic [63:0] ptw_addr,
    output logic        ptw_stall,

    input  logic        d_re,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [7:0]  d_wmask,
    output logic        d_stall,

    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic        i_stall,

    output logic [63:0] rdata,
    output logic [31:0] i_rdata,

    output logic [63:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata,
    input  logic        mem_stall,

    output logic [1:0]  arb_owner
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PTW  = 2'd1,
        OWN_D    = 2'd2,
        OWN_I    = 2'd3
    } owner_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    owner_t           winner;
    logic [63:0]      addr_q, addr_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [7:0]       wmask_q, wmask_d;
    logic             re_q, re_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             i_hi_q, i_hi_d;

    logic d_req;
    logic done;

    assign d_req = d_re | d_we;
    assign done  = (state_q == BUSY) & (re_q | we_q) & ~mem_stall;

    // A starved fetch overrides the fixed priority order.
    always_comb begin
        winner = OWN_NONE;
        if (i_req && starve_q == LIMIT) winner = OWN_I;
        else if (ptw_req)               winner = OWN_PTW;
        else if (d_req)                 winner = OWN_D;
        else if (i_req)                 winner = OWN_I;
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        re_d     = re_q;
        we_d     = we_q;
        starve_d = starve_q;
        i_hi_d   = i_hi_q;

        unique case (state_q)
            IDLE: begin
                if (winner != OWN_NONE) begin
                    state_d = BUSY;
                    owner_d = winner;
                    unique case (winner)
                        OWN_PTW: begin
                            addr_d  = ptw_addr;
                            re_d    = 1'b1;
                            we_d    = 1'b0;
                            wdata_d = '0;
                            wmask_d = '0;
                        end
                        OWN_D: begin
                            addr_d  = d_addr;
                            re_d    = ~d_we;
                            we_d    = d_we;
                            wdata_d = d_wdata;
                            wmask_d = d_wmask;
                        end
                        OWN_I: begin
                            addr_d  = i_addr;
                            re_d    = 1'b1;
                            we_d    = 1'b0;
                            wdata_d = '0;
                            wmask_d = '0;
                            i_hi_d  = i_addr[2];
                        end
                        default: ;
                    endcase

                    if (winner == OWN_I)
                        starve_d = '0;
                    else if (i_req && starve_q != LIMIT)
                        starve_d = starve_q + 1'b1;
                end
            end

            BUSY: begin
                if (!mem_stall) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            starve_q <= '0;
            i_hi_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            re_q     <= re_d;
            we_q     <= we_d;
            starve_q <= starve_d;
            i_hi_q   <= i_hi_d;
        end
    end

    // A requester is released only in the completion cycle of its own grant.
    assign ptw_stall = ptw_req & ~(done & (owner_q == OWN_PTW));
    assign d_stall   = d_req   & ~(done & (owner_q == OWN_D));
    assign i_stall   = i_req   & ~(done & (owner_q == OWN_I));

    assign rdata     = mem_rdata;
    assign i_rdata   = i_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];

    assign mem_addr  = addr_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign arb_owner = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory transactions are queued
// as requests are driven and compared when each transaction completes.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [1:0]  owner;
        logic [63:0] addr;
        logic        re;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        ptw_req;
    logic [63:0] ptw_addr;
    logic        ptw_stall;
    logic        d_re;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_wmask;
    logic        d_stall;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_stall;
    logic [63:0] rdata;
    logic [31:0] i_rdata;
    logic [63:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;
    logic        mem_stall;
    logic [1:0]  arb_owner;

    txn_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic logic [63:0] mem_model(input logic [63:0] a);
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
    endfunction

    function automatic txn_t mk(input logic [1:0] owner, input logic [63:0] addr,
                                input logic re, input logic we,
                                input logic [63:0] wdata, input logic [7:0] wmask);
        txn_t t;
        t.owner = owner;
        t.addr  = addr;
        t.re    = re;
        t.we    = we;
        t.wdata = wdata;
        t.wmask = wmask;
        return t;
    endfunction

    assign mem_rdata = mem_model(mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .ptw_req   (ptw_req),
        .ptw_addr  (ptw_addr),
        .ptw_stall (ptw_stall),
        .d_re      (d_re),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_stall   (d_stall),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_stall   (i_stall),
        .rdata     (rdata),
        .i_rdata   (i_rdata),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .mem_stall (mem_stall),
        .arb_owner (arb_owner)
    );

    // Waits (bounded) for the next completion cycle, then pops and compares.
    task automatic check_next_txn(input string name);
        txn_t e;
        txn_t o;
        int   n;
        n = 0;
        while (!((mem_re || mem_we) && !mem_stall) && n < 50) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (n >= 50) begin
            $display("FAIL %s: no completion within 50 cycles (queue depth %0d)", name, exp_q.size());
        end else if (exp_q.size() == 0) begin
            $display("FAIL %s: unexpected transaction owner=%0d addr=%h", name, arb_owner, mem_addr);
        end else begin
            e = exp_q.pop_front();
            o = mk(arb_owner, mem_addr, mem_re, mem_we, mem_wdata, mem_wmask);
            if (o !== e)
                $display("FAIL %s: got owner=%0d addr=%h re=%b we=%b wdata=%h wmask=%h, need owner=%0d addr=%h re=%b we=%b wdata=%h wmask=%h",
                         name, o.owner, o.addr, o.re, o.we, o.wdata, o.wmask,
                         e.owner, e.addr, e.re, e.we, e.wdata, e.wmask);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({mem_re, mem_we, arb_owner, mem_addr, mem_wdata, mem_wmask} !== '0)
            $display("FAIL reset_outputs: re=%b we=%b owner=%0d addr=%h wdata=%h wmask=%h, need all zero",
                     mem_re, mem_we, arb_owner, mem_addr, mem_wdata, mem_wmask);
        else pass_cnt++;
        d_re = 1'b1;
        #1;
        total_cnt++;
        if (d_stall !== 1'b1) $display("FAIL reset_stall_req: d_stall=%b, need 1", d_stall);
        else pass_cnt++;
        d_re = 1'b0;
        #1;
        total_cnt++;
        if (d_stall !== 1'b0) $display("FAIL reset_stall_idle: d_stall=%b, need 0", d_stall);
        else pass_cnt++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single_read();
        logic [63:0] exp_rd;
        exp_rd = mem_model(64'h8000_1000);
        @(posedge clk);
        #1;
        d_re = 1'b1; d_addr = 64'h8000_1000; d_wdata = '0; d_wmask = '0; mem_stall = 1'b0;
        exp_q.push_back(mk(2'd2, 64'h8000_1000, 1'b1, 1'b0, 64'h0, 8'h0));
        @(negedge clk);
        total_cnt++;
        if (d_stall !== 1'b1 || mem_re !== 1'b0)
            $display("FAIL read_cycle0: d_stall=%b mem_re=%b, need 1 and 0", d_stall, mem_re);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (d_stall !== 1'b0 || mem_re !== 1'b1)
            $display("FAIL read_cycle1: d_stall=%b mem_re=%b, need 0 and 1", d_stall, mem_re);
        else pass_cnt++;
        total_cnt++;
        if (rdata !== exp_rd) $display("FAIL read_rdata: got %h, need %h", rdata, exp_rd);
        else pass_cnt++;
        check_next_txn("single_read");
        d_re = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        @(posedge clk);
        #1;
        ptw_req = 1'b1; ptw_addr = 64'h8000_5000;
        d_re    = 1'b1; d_addr   = 64'h8000_6000;
        i_req   = 1'b1; i_addr   = 64'h8000_7000;
        exp_q.push_back(mk(2'd1, 64'h8000_5000, 1'b1, 1'b0, 64'h0, 8'h0));
        exp_q.push_back(mk(2'd2, 64'h8000_6000, 1'b1, 1'b0, 64'h0, 8'h0));
        exp_q.push_back(mk(2'd3, 64'h8000_7000, 1'b1, 1'b0, 64'h0, 8'h0));
        for (int k = 0; k < 3; k++) begin
            check_next_txn($sformatf("priority_grant%0d", k));
            if (k == 0) begin
                total_cnt++;
                if (d_stall !== 1'b1 || i_stall !== 1'b1)
                    $display("FAIL priority_losers_stall: d_stall=%b i_stall=%b, need 1 1", d_stall, i_stall);
                else pass_cnt++;
            end
            if (k == 0) ptw_req = 1'b0;
            if (k == 1) d_re    = 1'b0;
            if (k == 2) i_req   = 1'b0;
            @(negedge clk);
            total_cnt++;
            if (arb_owner !== 2'd0 || mem_re !== 1'b0)
                $display("FAIL priority_bubble%0d: owner=%0d mem_re=%b, need 0 0", k, arb_owner, mem_re);
            else pass_cnt++;
        end
    endtask

    task automatic test_write();
        @(posedge clk);
        #1;
        d_re = 1'b1; d_we = 1'b1; d_addr = 64'h8000_2000;
        d_wdata = 64'h0000_0000_DEAD_BEEF; d_wmask = 8'h0F;
        exp_q.push_back(mk(2'd2, 64'h8000_2000, 1'b0, 1'b1, 64'h0000_0000_DEAD_BEEF, 8'h0F));
        check_next_txn("write");
        d_re = 1'b0; d_we = 1'b0; d_wdata = '0; d_wmask = '0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        @(posedge clk);
        #1;
        ptw_req = 1'b1; ptw_addr = 64'h8000_8000;
        d_re    = 1'b1; d_addr   = 64'h8000_9000;
        i_req   = 1'b1; i_addr   = 64'h8000_A000;
        for (int r = 0; r < 2; r++) begin
            repeat (4) exp_q.push_back(mk(2'd1, 64'h8000_8000, 1'b1, 1'b0, 64'h0, 8'h0));
            exp_q.push_back(mk(2'd3, 64'h8000_A000, 1'b1, 1'b0, 64'h0, 8'h0));
            for (int k = 0; k < 5; k++) begin
                check_next_txn($sformatf("starve_r%0d_arb%0d", r, k + 1));
                if (k == 4) i_req = 1'b0;
                @(negedge clk);
            end
            if (r == 0) i_req = 1'b1;
        end
        ptw_req = 1'b0;
        d_re    = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch_wait();
        logic [63:0] m;
        logic [31:0] exp_i;
        int          high_cnt;
        m        = mem_model(64'h8000_0004);
        exp_i    = m[63:32];
        high_cnt = 0;
        @(posedge clk);
        #1;
        i_req = 1'b1; i_addr = 64'h8000_0004; mem_stall = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1 mem_stall = (c < 4);
            end
            @(negedge clk);
            if (i_stall === 1'b1) high_cnt++;
            if (c == 4) begin
                total_cnt++;
                if (i_stall !== 1'b0 || i_rdata !== exp_i)
                    $display("FAIL fetch_complete: i_stall=%b i_rdata=%h, need 0 %h", i_stall, i_rdata, exp_i);
                else pass_cnt++;
                i_req = 1'b0;
            end
        end
        total_cnt++;
        if (high_cnt !== 4) $display("FAIL fetch_stall_cycles: got %0d, need 4", high_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_busy();
        @(posedge clk);
        #1;
        d_re = 1'b1; d_addr = 64'h8000_3000; mem_stall = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (mem_re !== 1'b0 || arb_owner !== 2'd0)
            $display("FAIL reset_busy_async: mem_re=%b owner=%0d, need 0 0", mem_re, arb_owner);
        else pass_cnt++;
        total_cnt++;
        if (d_stall !== 1'b1) $display("FAIL reset_busy_stall: d_stall=%b, need 1", d_stall);
        else pass_cnt++;
        @(posedge clk);
        #1;
        d_re = 1'b0; mem_stall = 1'b0; rst = 1'b0;
        @(posedge clk);
        #1;
        d_re = 1'b1; d_addr = 64'h8000_4000;
        exp_q.push_back(mk(2'd2, 64'h8000_4000, 1'b1, 1'b0, 64'h0, 8'h0));
        @(negedge clk);
        total_cnt++;
        if (d_stall !== 1'b1) $display("FAIL post_reset_cycle0: d_stall=%b, need 1", d_stall);
        else pass_cnt++;
        check_next_txn("post_reset_read");
        d_re = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ptw_req = 1'b0; ptw_addr = '0;
        d_re = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        i_req = 1'b0; i_addr = '0;
        mem_stall = 1'b0;

        test_reset();
        test_single_read();
        test_priority();
        test_write();
        test_starvation();
        test_fetch_wait();
        test_reset_busy();

        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left, need 0", exp_q.size());
        else pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
